pet2001_arty: RTL and testbench

Board-level top for the PET 2001 emulator on the Arty: wraps the existing `pet2001_core` and adapts it to board I/O. It provides:
- the CPU clock-enable divider, reset synchronisation and the BTN soft reset;
- switch synchronisers and the status LED;
- one of two build-selected I/O sets: composite video plus a UART keyboard, or real-PET video plus a matrix keyboard.

---
 rtl/pet2001_pkg.sv | 31 +++
 rtl/pet2001_if.sv | 25 ++
 rtl/pet2001_uart.sv | 126 ++++++++++++
 rtl/pet2001_arty.sv | 215 +++++++++++++++++++++
 tb/tb_pet2001_arty.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pet2001_pkg.sv
// Shared constants, types and helpers for the PET 2001 Arty board top.
package pet2001_pkg;

   localparam int unsigned CPU_DIV_NORMAL  = 100;
   localparam int unsigned CPU_DIV_TURBO   = 25;
   localparam int unsigned HEARTBEAT_TICKS = 500_000;
   localparam int unsigned KEYROW_N        = 10;
   localparam int unsigned KEYCOL_N        = 8;
   localparam int unsigned ROWSEL_W        = 4;

   localparam logic [1:0] CVID_SYNC  = 2'b00;
   localparam logic [1:0] CVID_BLACK = 2'b01;
   localparam logic [1:0] CVID_WHITE = 2'b11;

   // Video signals coming out of the core
   typedef struct packed {
      logic pix;
      logic hsync;
      logic vsync;
   } vid_t;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

   // Composite DAC code for one core video sample
   function automatic logic [1:0] cvid_code(input vid_t v);
      if (v.hsync || v.vsync) return CVID_SYNC;
      return v.pix ? CVID_WHITE : CVID_BLACK;
   endfunction

endpackage

// File: rtl/pet2001_if.sv
// Board-top <-> pet2001_core signal bundle. The board top is the master,
// the core attaches through the slave modport.
interface pet2001_if;
   import pet2001_pkg::*;

   logic                cpu_en;
   logic                core_rst;
   logic                diag;
   logic [7:0]          key_data;
   logic                key_strobe;
   logic [KEYCOL_N-1:0] col;
   vid_t                vid;
   logic [ROWSEL_W-1:0] row_sel;

   modport master (
      output cpu_en, core_rst, diag, key_data, key_strobe, col,
      input  vid, row_sel
   );

   modport slave (
      input  cpu_en, core_rst, diag, key_data, key_strobe, col,
      output vid, row_sel
   );

endinterface

// File: rtl/pet2001_uart.sv
// 8N1 keyboard receiver with echo transmitter. Bytes arriving while the
// echo is still busy reach the core but are not echoed.
module pet2001_uart
   import pet2001_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] key_data,
   output logic       key_strobe
);

   localparam int unsigned DIV   = CLK_HZ / BAUD;
   localparam int unsigned HALF  = DIV / 2;
   localparam int unsigned CNT_W = $clog2(DIV + 1);

   rx_state_t        rx_st;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_sr;
   logic             rx_prev;

   tx_state_t        tx_st;
   logic [CNT_W-1:0] tx_cnt;
   logic [3:0]       tx_bit;
   logic [8:0]       tx_sr;

   // Receiver: falling-edge start, mid-bit recheck and sampling, stop check
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st      <= RX_IDLE;
         rx_cnt     <= '0;
         rx_bit     <= '0;
         rx_sr      <= '0;
         rx_prev    <= 1'b1;
         key_data   <= '0;
         key_strobe <= 1'b0;
      end else begin
         rx_prev    <= rx;
         key_strobe <= 1'b0;
         case (rx_st)
            RX_IDLE: begin
               if (rx_prev && !rx) begin
                  rx_st  <= RX_START;
                  rx_cnt <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == CNT_W'(HALF - 1)) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  rx_st  <= rx ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt == CNT_W'(DIV - 1)) begin
                  rx_cnt <= '0;
                  rx_sr  <= {rx, rx_sr[7:1]};
                  if (rx_bit == 3'd7) rx_st  <= RX_STOP;
                  else                rx_bit <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt == CNT_W'(DIV - 1)) begin
                  rx_cnt <= '0;
                  rx_st  <= RX_IDLE;
                  if (rx) begin
                     key_data   <= rx_sr;
                     key_strobe <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + CNT_W'(1);
               end
            end
            default: rx_st <= RX_IDLE;
         endcase
      end
   end

   // Echo transmitter: start bit goes out on the clock after key_strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st  <= TX_IDLE;
         tx     <= 1'b1;
         tx_sr  <= '1;
         tx_cnt <= '0;
         tx_bit <= '0;
      end else begin
         case (tx_st)
            TX_IDLE: begin
               if (key_strobe) begin
                  tx_st  <= TX_BUSY;
                  tx     <= 1'b0;
                  tx_sr  <= {1'b1, key_data};
                  tx_cnt <= '0;
                  tx_bit <= '0;
               end
            end
            TX_BUSY: begin
               if (tx_cnt == CNT_W'(DIV - 1)) begin
                  tx_cnt <= '0;
                  if (tx_bit == 4'd9) begin
                     tx_st <= TX_IDLE;
                  end else begin
                     tx     <= tx_sr[0];
                     tx_sr  <= {1'b1, tx_sr[8:1]};
                     tx_bit <= tx_bit + 4'd1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + CNT_W'(1);
               end
            end
            default: tx_st <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pet2001_arty.sv
// Arty board top for the PET 2001 emulator: CPU clock enable, reset and
// button handling, heartbeat LED and board I/O. The core attaches through
// the pet2001_if port. Define PET_REAL_EN for real-PET video and matrix
// keyboard; otherwise composite video and a UART keyboard are built.
module pet2001_arty
   import pet2001_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned BAUD            = 115_200,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned HB_TICKS        = HEARTBEAT_TICKS
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [2:0]          SW,
   input  logic                BTN,
   output logic                LED,
   pet2001_if.master           core,
`ifdef PET_REAL_EN
   output logic                PET_VID_DATA_N,
   output logic                PET_VID_HORZ_N,
   output logic                PET_VID_VERT_N,
   output wire [KEYROW_N-1:0]  KEYROW,
   input  logic [KEYCOL_N-1:0] KEYCOL
`else
   output logic [1:0]          CVID,
   input  logic                UART_TXD_IN,
   output logic                UART_RXD_OUT
`endif
);

   localparam int unsigned DIV_W = $clog2(CPU_DIV_NORMAL);
   localparam int unsigned HB_W  = $clog2(HB_TICKS + 1);
   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]       rst_sync;
   logic             rst_n;
   logic [2:0]       sw_m, sw_s;
   logic             btn_m, btn_s;
   logic             btn_db;
   logic [DB_W-1:0]  db_cnt;
   logic [DIV_W-1:0] div_cnt, div_last;
   logic             cpu_en;
   logic [HB_W-1:0]  hb_cnt;
   logic             core_rst_q;
   logic             diag_q;

   // Reset assertion is asynchronous, release goes through two flops
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // Switch and button synchronisers
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         sw_m  <= '0;
         sw_s  <= '0;
         btn_m <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         sw_m  <= SW;
         sw_s  <= sw_m;
         btn_m <= BTN;
         btn_s <= btn_m;
      end
   end

   // Button debounce: a new level must persist DEBOUNCE_CYCLES clocks
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt <= '0;
         btn_db <= 1'b0;
      end else if (btn_s == btn_db) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         btn_db <= btn_s;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   // Core reset and diag pass-through
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         core_rst_q <= 1'b1;
         diag_q     <= 1'b0;
      end else begin
         core_rst_q <= btn_db;
         diag_q     <= sw_s[2];
      end
   end

   // CPU clock-enable divider; pause/turbo are picked up at each wrap
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         div_last <= DIV_W'(CPU_DIV_NORMAL - 1);
         cpu_en   <= 1'b0;
      end else begin
         cpu_en <= 1'b0;
         if (div_cnt == div_last) begin
            div_cnt  <= '0;
            div_last <= sw_s[1] ? DIV_W'(CPU_DIV_TURBO - 1) : DIV_W'(CPU_DIV_NORMAL - 1);
            cpu_en   <= !sw_s[0];
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   // Heartbeat: toggle LED every HB_TICKS CPU enables
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         hb_cnt <= '0;
         LED    <= 1'b0;
      end else if (cpu_en) begin
         if (hb_cnt == HB_W'(HB_TICKS - 1)) begin
            hb_cnt <= '0;
            LED    <= ~LED;
         end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
         end
      end
   end

   assign core.cpu_en   = cpu_en;
   assign core.core_rst = core_rst_q;
   assign core.diag     = diag_q;

`ifdef PET_REAL_EN
   logic [KEYCOL_N-1:0] col_m, col_n;
   logic [ROWSEL_W-1:0] row_q;
   logic                row_drv;

   // Active-low video, one clock behind the core
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         PET_VID_DATA_N <= 1'b1;
         PET_VID_HORZ_N <= 1'b1;
         PET_VID_VERT_N <= 1'b1;
      end else begin
         PET_VID_DATA_N <= ~core.vid.pix;
         PET_VID_HORZ_N <= ~core.vid.hsync;
         PET_VID_VERT_N <= ~core.vid.vsync;
      end
   end

   // Row select register and column synchroniser (inverted for the core)
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         row_q   <= '0;
         row_drv <= 1'b0;
         col_m   <= '0;
         col_n   <= '1;
      end else begin
         row_q   <= core.row_sel;
         row_drv <= core.row_sel < ROWSEL_W'(KEYROW_N);
         col_m   <= KEYCOL;
         col_n   <= ~col_m;
      end
   end

   // Open-drain style rows: only the selected row is driven
   for (genvar i = 0; i < KEYROW_N; i++) begin : g_row
      assign KEYROW[i] = (row_drv && row_q == ROWSEL_W'(i)) ? 1'b1 : 1'bz;
   end

   assign core.col        = col_n;
   assign core.key_data   = '0;
   assign core.key_strobe = 1'b0;
`else
   logic       rx_m, rx_s;
   logic [7:0] key_data;
   logic       key_strobe;
   logic       unused_row_sel;

   // Composite DAC code, one clock behind the core
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) CVID <= CVID_BLACK;
      else        CVID <= cvid_code(core.vid);
   end

   // Serial input synchroniser; line idles high
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= UART_TXD_IN;
         rx_s <= rx_m;
      end
   end

   pet2001_uart #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_uart (
      .clk        (CLK),
      .rst_n      (rst_n),
      .rx         (rx_s),
      .tx         (UART_RXD_OUT),
      .key_data   (key_data),
      .key_strobe (key_strobe)
   );

   assign core.key_data   = key_data;
   assign core.key_strobe = key_strobe;
   assign core.col        = '1;
   assign unused_row_sel  = ^core.row_sel;
`endif

endmodule

// File: tb/tb_pet2001_arty.sv
// Directed bench for pet2001_arty; the bench plays the core side of pet2001_if.
module tb_pet2001_arty;
   import pet2001_pkg::*;

   localparam int unsigned DIV = 20;
   localparam int unsigned DEB = 200;
   localparam int unsigned HB  = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] sw;
   logic       btn;
   logic       led;
`ifdef PET_REAL_EN
   logic       vid_data_n, vid_horz_n, vid_vert_n;
   wire  [9:0] keyrow;
   logic [7:0] keycol;
   assign keycol = {2'b00, (keyrow[3] === 1'b1), 5'b00000};
`else
   logic [1:0] cvid;
   logic       uart_in;
   logic       uart_out;
`endif

   pet2001_if core_if ();

   pet2001_arty #(
      .CLK_HZ          (100_000_000),
      .BAUD            (5_000_000),
      .DEBOUNCE_CYCLES (DEB),
      .HB_TICKS        (HB)
   ) dut (
      .CLK            (clk),
      .RST_N          (rst_n),
      .SW             (sw),
      .BTN            (btn),
      .LED            (led),
      .core           (core_if),
`ifdef PET_REAL_EN
      .PET_VID_DATA_N (vid_data_n),
      .PET_VID_HORZ_N (vid_horz_n),
      .PET_VID_VERT_N (vid_vert_n),
      .KEYROW         (keyrow),
      .KEYCOL         (keycol)
`else
      .CVID           (cvid),
      .UART_TXD_IN    (uart_in),
      .UART_RXD_OUT   (uart_out)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Core-side monitor, sampled on the falling edge
   int unsigned en_cnt = 0, en_t_last = 0, en_t_prev = 0;
   int unsigned stb_cnt = 0;
   logic [7:0]  stb_data = 8'h00;
   bit          rst_seen = 1'b0;
   always @(negedge clk) begin
      if (core_if.cpu_en === 1'b1) begin
         en_cnt++;
         en_t_prev = en_t_last;
         en_t_last = cyc;
      end
      if (core_if.key_strobe === 1'b1) begin
         stb_cnt++;
         stb_data = core_if.key_data;
      end
      if (core_if.core_rst === 1'b1) rst_seen = 1'b1;
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int unsigned act,
                              input int unsigned lo, input int unsigned hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

`ifndef PET_REAL_EN
   task automatic send_byte(input logic [7:0] d, input logic stop, input int unsigned stop_len);
      uart_in = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         uart_in = d[i];
         tick(DIV);
      end
      uart_in = stop;
      tick(stop_len);
      uart_in = 1'b1;
   endtask

   task automatic capture_echo(input int unsigned limit, output logic [7:0] d, output bit ok);
      ok = 1'b0;
      d  = 8'h00;
      for (int i = 0; i < int'(limit) && uart_out !== 1'b0; i++) tick(1);
      if (uart_out !== 1'b0) return;
      tick(DIV / 2);
      if (uart_out !== 1'b0) return;
      for (int i = 0; i < 8; i++) begin
         tick(DIV);
         d[i] = uart_out;
      end
      tick(DIV);
      ok = (uart_out === 1'b1);
   endtask
`endif

   typedef struct {
      logic [2:0]  sw;
      int unsigned period;
   } div_vec_t;

   typedef struct {
      vid_t       vid;
      logic [1:0] cvid;
   } vid_vec_t;

   div_vec_t    dv[6];
   vid_vec_t    vv[7];
   int unsigned t0, n0, s0;
   logic        led0;
   logic [7:0]  echo_d, echo_d2;
   bit          echo_ok, echo_ok2;
   logic [7:0]  rx_bytes[3];

   initial begin
      #600_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      dv[0] = '{3'b000, 100};
      dv[1] = '{3'b010, 25};
      dv[2] = '{3'b110, 25};
      dv[3] = '{3'b001, 0};
      dv[4] = '{3'b011, 0};
      dv[5] = '{3'b000, 100};

      vv[0] = '{'{pix:1'b1, hsync:1'b0, vsync:1'b0}, 2'b11};
      vv[1] = '{'{pix:1'b0, hsync:1'b0, vsync:1'b0}, 2'b01};
      vv[2] = '{'{pix:1'b0, hsync:1'b1, vsync:1'b0}, 2'b00};
      vv[3] = '{'{pix:1'b1, hsync:1'b1, vsync:1'b0}, 2'b00};
      vv[4] = '{'{pix:1'b1, hsync:1'b0, vsync:1'b1}, 2'b00};
      vv[5] = '{'{pix:1'b0, hsync:1'b1, vsync:1'b1}, 2'b00};
      vv[6] = '{'{pix:1'b1, hsync:1'b0, vsync:1'b0}, 2'b11};

      rx_bytes[0] = 8'h41;
      rx_bytes[1] = 8'hA5;
      rx_bytes[2] = 8'h00;

      rst_n = 1'b0;
      sw    = 3'b000;
      btn   = 1'b0;
      core_if.vid     = '0;
      core_if.row_sel = 4'd15;
`ifndef PET_REAL_EN
      uart_in = 1'b1;
`endif
      tick(10);

      // Reset state
      check("rst_led", 32'(led), 32'h0);
      check("rst_core_rst", 32'(core_if.core_rst), 32'h1);
      check("rst_cpu_en", 32'(core_if.cpu_en), 32'h0);
`ifdef PET_REAL_EN
      check("rst_vid_n", 32'({vid_data_n, vid_horz_n, vid_vert_n}), 32'h7);
      check("rst_keyrow", 32'(keyrow), {22'b0, {10{1'bz}}});
`else
      check("rst_cvid", 32'(cvid), 32'h1);
      check("rst_txd", 32'(uart_out), 32'h1);
      check("rst_strobe", 32'(core_if.key_strobe), 32'h0);
`endif

      // Heartbeat: first toggle after HB enables of 100 clocks
      rst_n = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 3000 && led !== 1'b1; i++) tick(1);
      check_range("hb_first_toggle", cyc - t0, 1995, 2015);
      check("core_rst_released", 32'(core_if.core_rst), 32'h0);

      // Divider table: pulse count in a 400-clock window and pulse spacing
      for (int i = 0; i < 6; i++) begin
         sw = dv[i].sw;
         tick(150);
         n0 = en_cnt;
         tick(400);
         check($sformatf("div%0d_pulses", i), en_cnt - n0,
               (dv[i].period == 0) ? 32'd0 : 400 / dv[i].period);
         if (dv[i].period != 0)
            check($sformatf("div%0d_period", i), en_t_last - en_t_prev, dv[i].period);
         check($sformatf("div%0d_diag", i), 32'(core_if.diag), 32'(dv[i].sw[2]));
      end

      // Pause freezes the heartbeat
      sw = 3'b001;
      tick(150);
      led0 = led;
      n0 = en_cnt;
      tick(2500);
      check("pause_led_frozen", 32'(led), 32'(led0));
      check("pause_no_en", en_cnt - n0, 32'd0);
      sw = 3'b000;
      tick(150);

`ifdef PET_REAL_EN
      // Row drive and column sense through the tie of KEYCOL[5] to KEYROW[3]
      check("col_idle", 32'(core_if.col), 32'hFF);
      core_if.row_sel = 4'd3;
      tick(1);
      check("keyrow_sel3", 32'(keyrow), {22'b0, 10'bzzzzzz1zzz});
      tick(2);
      check("col_pressed", 32'(core_if.col), 32'hDF);
      core_if.row_sel = 4'd12;
      tick(1);
      check("keyrow_sel12", 32'(keyrow), {22'b0, {10{1'bz}}});
      tick(2);
      check("col_released", 32'(core_if.col), 32'hFF);
      core_if.row_sel = 4'd9;
      tick(1);
      check("keyrow_sel9", 32'(keyrow), {22'b0, 10'b1zzzzzzzzz});

      core_if.vid = '{pix:1'b1, hsync:1'b0, vsync:1'b0};
      tick(1);
      check("pet_vid_pix", 32'({vid_data_n, vid_horz_n, vid_vert_n}), 32'h3);
      core_if.vid = '{pix:1'b0, hsync:1'b1, vsync:1'b1};
      tick(1);
      check("pet_vid_sync", 32'({vid_data_n, vid_horz_n, vid_vert_n}), 32'h4);
`else
      // Composite table: old value before the edge, new value one clock later
      for (int i = 0; i < 7; i++) begin
         core_if.vid = vv[i].vid;
         #1;
         check($sformatf("cvid%0d_hold", i), 32'(cvid), (i == 0) ? 32'h1 : 32'(vv[i-1].cvid));
         tick(1);
         check($sformatf("cvid%0d", i), 32'(cvid), 32'(vv[i].cvid));
      end

      // Good bytes: strobe with data and full echo
      for (int i = 0; i < 3; i++) begin
         s0 = stb_cnt;
         fork
            send_byte(rx_bytes[i], 1'b1, DIV);
            capture_echo(12 * DIV, echo_d, echo_ok);
         join
         tick(2 * DIV);
         check($sformatf("rx%0d_strobes", i), stb_cnt - s0, 32'd1);
         check($sformatf("rx%0d_data", i), 32'(stb_data), 32'(rx_bytes[i]));
         check($sformatf("rx%0d_echo_ok", i), 32'(echo_ok), 32'h1);
         check($sformatf("rx%0d_echo_data", i), 32'(echo_d), 32'(rx_bytes[i]));
      end

      // Framing error: no strobe, no echo
      s0 = stb_cnt;
      fork
         send_byte(8'h5A, 1'b0, DIV);
         capture_echo(15 * DIV, echo_d, echo_ok);
      join
      tick(2 * DIV);
      check("frame_err_strobes", stb_cnt - s0, 32'd0);
      check("frame_err_no_echo", 32'(echo_ok), 32'h0);

      // Second byte lands while the echo of the first is still going out
      s0 = stb_cnt;
      fork
         begin
            send_byte(8'h96, 1'b1, DIV / 2 + 6);
            send_byte(8'h3E, 1'b1, DIV);
         end
         begin
            capture_echo(12 * DIV, echo_d, echo_ok);
            capture_echo(15 * DIV, echo_d2, echo_ok2);
         end
      join
      check("busy_strobes", stb_cnt - s0, 32'd2);
      check("busy_last_data", 32'(stb_data), 32'h3E);
      check("busy_echo1", 32'(echo_d), 32'h96);
      check("busy_echo1_ok", 32'(echo_ok), 32'h1);
      check("busy_no_echo2", 32'(echo_ok2), 32'h0);

      // Reset in the middle of a frame, then a clean byte
      s0 = stb_cnt;
      uart_in = 1'b0;
      tick(3 * DIV);
      rst_n = 1'b0;
      tick(10);
      check("midrst_txd", 32'(uart_out), 32'h1);
      check("midrst_cvid", 32'(cvid), 32'h1);
      check("midrst_led", 32'(led), 32'h0);
      uart_in = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(2 * DIV);
      check("midrst_no_strobe", stb_cnt - s0, 32'd0);
      fork
         send_byte(8'h3C, 1'b1, DIV);
         capture_echo(12 * DIV, echo_d, echo_ok);
      join
      tick(2 * DIV);
      check("midrst_strobes", stb_cnt - s0, 32'd1);
      check("midrst_data", 32'(stb_data), 32'h3C);
      check("midrst_echo", 32'(echo_d), 32'h3C);
      check("midrst_echo_ok", 32'(echo_ok), 32'h1);
`endif

      // Debounce: short glitch ignored
      tick(10);
      rst_seen = 1'b0;
      btn = 1'b1;
      tick(100);
      btn = 1'b0;
      tick(400);
      check("btn_glitch_no_rst", 32'(rst_seen), 32'h0);

      // Debounce: long press asserts reset until release is stable
      btn = 1'b1;
      tick(150);
      check("btn_press_early", 32'(core_if.core_rst), 32'h0);
      tick(DEB + 2 - 150);
      btn = 1'b0;
      t0 = cyc;
      tick(5);
      check("btn_press_rst", 32'(core_if.core_rst), 32'h1);
      for (int i = 0; i < 400 && core_if.core_rst !== 1'b0; i++) tick(1);
      check_range("btn_release_time", cyc - t0, 195, 215);
      check("btn_rst_cleared", 32'(core_if.core_rst), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
